recoded_f32_to_f64_arbiter: RTL and testbench
=============================================

# recoded_f32_to_f64_arbiter

Shares one recoded single-to-double conversion datapath among `NUM_REQ` requesters, with round-robin arbitration, a two-stage registered pipeline and per-response tagging. Each requester presents 33-bit recoded single operands on a valid/ready port. A single valid/ready response port returns 65-bit recoded doubles with exception flags and requester identity. It also accumulates sticky exception flags for the FPU status path, and sits between the integer/load issue ports and the FPU register-file write arbiter.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requester ports (2..8).
- `TAG_BITS`, 4: opaque per-request tag width, returned unchanged.
- `ID_BITS`, 2: width of requester index; must equal ceil(log2(`NUM_REQ`)).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester accept; at most one bit high per cycle.
- `req_data` in `NUM_REQ*33`: recoded single operand, requester i at bits [33i+32:33i].
- `req_tag` in `NUM_REQ*TAG_BITS`: per-requester tag, same packing.
- `resp_valid` out 1: response valid.
- `resp_ready` in 1: consumer accept.
- `resp_data` out 65: recoded double result.
- `resp_flags` out 5: {invalid, divByZero, overflow, underflow, inexact} for this result.
- `resp_id` out `ID_BITS`: index of the originating requester.
- `resp_tag` out `TAG_BITS`: tag of the originating request.
- `flags_sticky` out 5: OR of `resp_flags` over all delivered responses since reset or clear.
- `flags_clear` in 1: clear sticky flags.

## Operation
- Conversion, combinational between S1 and S2:
  - Sign copied.
  - 3-bit exponent code = in[31:29].
  - Exponent by code: 000 -> 12'h000; 001/010/011 -> {4'b0111, in[30:23]}; 100/101 -> {4'b1000, in[30:23]}; 110 -> 12'hC00; 111 -> 12'hE00.
  - out[51] = in[22] | sNaN; out[50:29] = in[21:0]; out[28:0] = 0.
  - sNaN = (code==111) & ~in[22]; flags = {sNaN, 4'b0}.
- Pipeline:
  - S1 register holds {operand, tag, id, valid}.
  - S2 register holds {result, flags, tag, id, valid}; S2 drives all `resp_*` outputs directly.
  - `s2_adv` = ~S2.valid | `resp_ready`.
  - `s1_adv` = ~S1.valid | `s2_adv`.
  - S2 loads from S1 when `s2_adv`.
  - S1 loads the granted request when `s1_adv`; otherwise S1 is cleared or held as appropriate.
- Arbitration:
  - Round-robin pointer `rr` (`ID_BITS`).
  - Grant goes to the first i with `req_valid[i]` set, searching `rr`, `rr+1`, ... modulo `NUM_REQ`.
  - `req_ready[i]` = grant[i] & `s1_adv` (combinational; may depend on `req_valid`).
  - On acceptance of i, `rr` <= (i+1) mod `NUM_REQ`. No change without acceptance.
  - Wrap: i = `NUM_REQ`-1 sets `rr` to 0.
- Requesters must hold valid/data/tag stable until accepted; the block does not drop or reorder. Responses return in acceptance order.
- Sticky flags: next = (`flags_clear` ? 0 : `flags_sticky`) | (`resp_valid` & `resp_ready` ? `resp_flags` : 0). A flag delivered in the clear cycle survives.

## Timing
- Reset (`reset_n` low at edge): S1.valid = S2.valid = 0, `rr` = 0, `flags_sticky` = 0. `resp_data`/`resp_flags`/`resp_tag`/`resp_id` reset to 0.
- During reset `req_ready` = 0. Reset mid-operation discards in-flight entries with no response.
- Latency: request accepted at edge N produces `resp_valid` high after edge N+1 when unstalled, i.e. visible 2 cycles after `req_valid` is first seen with ready.
- Throughput: 1 per cycle with `resp_ready` held high.
- Backpressure: `resp_valid` and all `resp_*` held stable until `resp_ready`. With `resp_ready` low, the pipeline fills both stages and then `req_ready` = 0.
- Full throughput during single-cycle stalls is not required; pipeline depth is exactly 2.

## Test plan
- Reset, then requester 0 sends 33'h0_8000_0000, tag 3 -> two cycles later `resp_data` = 65'h0_8000_0000_0000_0000, flags 0, id 0, tag 3.
- Requester 2 sends sNaN 33'h0_E000_0001 -> `resp_data` = 65'h0_E008_0000_2000_0000, `resp_flags` = 5'b10000, `flags_sticky` = 5'b10000 after the handshake. Then `flags_clear` pulse returns it to 0.
- All 4 requesters valid continuously, `resp_ready`=1 -> grants 0,1,2,3,0,... with `resp_id` sequence identical, one response per cycle.
- `resp_ready` held low 5 cycles with all requesters valid -> exactly 2 accepts, then `req_ready`=0. `resp_*` stable. On release, no loss or duplication, order preserved.
- Zero input 33'h1_0000_0000 and infinity code 110 (33'h0_C000_0000) -> 65'h1_0000_0000_0000_0000 and 65'h0_C000_0000_0000_0000.
- `reset_n` asserted with both stages full -> no `resp_valid` after reset. `rr` returns to 0, so the next grant goes to requester 0 when all are valid.

Source files
------------

// File: rtl/recoded_f32_to_f64_arbiter.sv
// ---------------------------------------------------------------------------
// recoded_f32_to_f64_arbiter
//
// Purpose:
//   Shares one recoded single -> recoded double conversion datapath among
//   NUM_REQ requesters. A round-robin arbiter feeds a two-stage registered
//   pipeline (S1 holds the operand, S2 holds the converted result). Each
//   response carries its requester index and the request's opaque tag.
//   Exception flags of every delivered response are accumulated into a
//   sticky status register.
//
// Ports:
//   clk           in  1                 single clock, rising edge
//   reset_n       in  1                 synchronous active-low reset
//   req_valid     in  NUM_REQ           per-requester request valid
//   req_ready     out NUM_REQ           per-requester accept (one-hot or 0)
//   req_data      in  NUM_REQ*33        recoded f32 operands, req i at [33i +: 33]
//   req_tag       in  NUM_REQ*TAG_BITS  per-requester tags, same packing
//   resp_valid    out 1                 response valid
//   resp_ready    in  1                 consumer accept
//   resp_data     out 65                recoded f64 result
//   resp_flags    out 5                 {invalid, divByZero, overflow, underflow, inexact}
//   resp_id       out ID_BITS           originating requester index
//   resp_tag      out TAG_BITS          originating request tag
//   flags_sticky  out 5                 OR of delivered resp_flags since reset/clear
//   flags_clear   in  1                 clear sticky flags
// ---------------------------------------------------------------------------
module recoded_f32_to_f64_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int TAG_BITS = 4,
    parameter int ID_BITS  = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*33-1:0]        req_data,
    input  logic [NUM_REQ*TAG_BITS-1:0]  req_tag,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [64:0]                  resp_data,
    output logic [4:0]                   resp_flags,
    output logic [ID_BITS-1:0]           resp_id,
    output logic [TAG_BITS-1:0]          resp_tag,
    output logic [4:0]                   flags_sticky,
    input  logic                         flags_clear
);

    // Round-robin pointer: the requester searched first this cycle.
    logic [ID_BITS-1:0]  rr;

    // Arbiter result.
    logic                grant_found;
    logic [ID_BITS-1:0]  grant_idx;
    logic                accept;
    logic [ID_BITS-1:0]  rr_next;

    // Stage 1: operand waiting for conversion.
    logic                s1_valid;
    logic [32:0]         s1_operand;
    logic [TAG_BITS-1:0] s1_tag;
    logic [ID_BITS-1:0]  s1_id;

    // Stage 2: converted result, drives the response port directly.
    logic                s2_valid;
    logic [64:0]         s2_data;
    logic [4:0]          s2_flags;
    logic [TAG_BITS-1:0] s2_tag;
    logic [ID_BITS-1:0]  s2_id;

    // Pipeline advance conditions.
    logic                s2_adv;
    logic                s1_adv;

    // Conversion datapath signals.
    logic [2:0]          conv_code;
    logic                conv_snan;
    logic [11:0]         conv_exp;
    logic [64:0]         conv_data;
    logic [4:0]          conv_flags;

    // A stage may accept new content when it is empty or when its content
    // is leaving this cycle. S1 can only drain into S2, so S1 advancing
    // depends on S2 advancing.
    always_comb begin
        s2_adv = ~s2_valid | resp_ready;
        s1_adv = ~s1_valid | s2_adv;
    end

    // Round-robin search: start at rr and walk upward modulo NUM_REQ; the
    // first requester with valid set wins. Only the first hit is kept, so
    // later candidates in the walk cannot override it.
    always_comb begin
        logic [ID_BITS-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_BITS'((int'(rr) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // An accept happens when a requester is granted and S1 can take it.
    // req_ready is forced low while reset is asserted so no requester
    // believes it was accepted by a pipeline that is being flushed.
    // The pointer moves one past the accepted requester, wrapping at the
    // last index so non-power-of-two NUM_REQ stays in range.
    always_comb begin
        accept    = grant_found & s1_adv;
        req_ready = '0;
        if (accept && reset_n) begin
            req_ready = NUM_REQ'(1) << grant_idx;
        end
        if (int'(grant_idx) == NUM_REQ - 1) begin
            rr_next = '0;
        end else begin
            rr_next = grant_idx + 1'b1;
        end
    end

    // Arbitration pointer register. Only an actual accept moves it, so a
    // stalled pipeline keeps offering the same requester.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr <= '0;
        end else if (accept) begin
            rr <= rr_next;
        end
    end

    // Stage 1 register. When S1 advances it either captures the granted
    // request or becomes empty; when it cannot advance it holds.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid   <= 1'b0;
            s1_operand <= '0;
            s1_tag     <= '0;
            s1_id      <= '0;
        end else if (s1_adv) begin
            s1_valid <= grant_found;
            if (grant_found) begin
                s1_operand <= req_data[int'(grant_idx)*33 +: 33];
                s1_tag     <= req_tag[int'(grant_idx)*TAG_BITS +: TAG_BITS];
                s1_id      <= grant_idx;
            end
        end
    end

    // Recoded single -> recoded double conversion. The top three exponent
    // bits form a class code: zero, normal/subnormal ranges (rebiased by
    // prefixing 0111 or 1000), infinity and NaN. A NaN with the quiet bit
    // clear is signalling: it is quieted on output and raises invalid.
    // The 23-bit fraction is left-aligned into the 52-bit fraction field.
    always_comb begin
        conv_code = s1_operand[31:29];
        conv_snan = (conv_code == 3'b111) & ~s1_operand[22];
        conv_exp  = 12'h000;
        case (conv_code)
            3'b000:                 conv_exp = 12'h000;
            3'b001, 3'b010, 3'b011: conv_exp = {4'b0111, s1_operand[30:23]};
            3'b100, 3'b101:         conv_exp = {4'b1000, s1_operand[30:23]};
            3'b110:                 conv_exp = 12'hC00;
            default:                conv_exp = 12'hE00;
        endcase
        conv_data  = {s1_operand[32], conv_exp,
                      s1_operand[22] | conv_snan, s1_operand[21:0], 29'b0};
        conv_flags = {conv_snan, 4'b0000};
    end

    // Stage 2 register. The payload is only rewritten when S1 hands over a
    // real entry, so resp_* stay put while S2 is empty and while it waits
    // for resp_ready.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_flags <= '0;
            s2_tag   <= '0;
            s2_id    <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data  <= conv_data;
                s2_flags <= conv_flags;
                s2_tag   <= s1_tag;
                s2_id    <= s1_id;
            end
        end
    end

    // Sticky exception flags. Clearing and accumulation happen in the same
    // expression so a flag delivered during the clear cycle is not lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_sticky <= '0;
        end else begin
            flags_sticky <= (flags_clear ? 5'b00000 : flags_sticky)
                          | ((s2_valid && resp_ready) ? s2_flags : 5'b00000);
        end
    end

    // The response port is S2 itself.
    always_comb begin
        resp_valid = s2_valid;
        resp_data  = s2_data;
        resp_flags = s2_flags;
        resp_tag   = s2_tag;
        resp_id    = s2_id;
    end

endmodule

// File: tb/tb_recoded_f32_to_f64_arbiter.sv
// ---------------------------------------------------------------------------
// tb_recoded_f32_to_f64_arbiter
//
// Purpose:
//   Directed self-checking bench for recoded_f32_to_f64_arbiter with four
//   requesters. Inputs are driven and outputs sampled on the falling edge,
//   the DUT acts on the rising edge. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_recoded_f32_to_f64_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int TAG_BITS = 4;
    localparam int ID_BITS  = 2;

    logic                        clk;
    logic                        reset_n;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*33-1:0]       req_data;
    logic [NUM_REQ*TAG_BITS-1:0] req_tag;
    logic                        resp_valid;
    logic                        resp_ready;
    logic [64:0]                 resp_data;
    logic [4:0]                  resp_flags;
    logic [ID_BITS-1:0]          resp_id;
    logic [TAG_BITS-1:0]         resp_tag;
    logic [4:0]                  flags_sticky;
    logic                        flags_clear;

    int compared;
    int mismatched;

    recoded_f32_to_f64_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .TAG_BITS (TAG_BITS),
        .ID_BITS  (ID_BITS)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .req_tag      (req_tag),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_flags   (resp_flags),
        .resp_id      (resp_id),
        .resp_tag     (resp_tag),
        .flags_sticky (flags_sticky),
        .flags_clear  (flags_clear)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [64:0] got,
                               input logic [64:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Drives one requester's valid, operand and tag.
    task automatic applyStimulus(input int idx, input logic valid,
                                 input logic [32:0] data, input logic [3:0] tag);
        req_valid[idx]               = valid;
        req_data[idx*33 +: 33]       = data;
        req_tag[idx*TAG_BITS +: 4]   = tag;
    endtask

    // One isolated request with resp_ready high: accept, wait for the
    // result two edges later, check it, and let it be consumed.
    task automatic runSingle(input string name, input int idx,
                             input logic [32:0] data, input logic [3:0] tag,
                             input logic [64:0] exp_data, input logic [4:0] exp_flags);
        @(negedge clk);
        applyStimulus(idx, 1'b1, data, tag);
        #1;
        checkOutput({name, "_ready"}, 65'(req_ready), 65'(4'b0001 << idx));
        @(negedge clk);
        applyStimulus(idx, 1'b0, data, tag);
        checkOutput({name, "_s1_valid"}, 65'(resp_valid), 65'd0);
        @(negedge clk);
        checkOutput({name, "_valid"}, 65'(resp_valid), 65'd1);
        checkOutput({name, "_data"},  resp_data, exp_data);
        checkOutput({name, "_flags"}, 65'(resp_flags), 65'(exp_flags));
        checkOutput({name, "_id"},    65'(resp_id), 65'(idx));
        checkOutput({name, "_tag"},   65'(resp_tag), 65'(tag));
        @(negedge clk);
    endtask

    // Stimulus sequence.
    initial begin
        int accepts;
        compared    = 0;
        mismatched  = 0;
        reset_n     = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        req_tag     = '0;
        resp_ready  = 1'b1;
        flags_clear = 1'b0;

        // Reset state, with a requester already valid.
        applyStimulus(0, 1'b1, 33'h0_8000_0000, 4'd3);
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready",  65'(req_ready), 65'd0);
        checkOutput("rst_resp_valid", 65'(resp_valid), 65'd0);
        checkOutput("rst_resp_data",  resp_data, 65'd0);
        checkOutput("rst_sticky",     65'(flags_sticky), 65'd0);
        applyStimulus(0, 1'b0, 33'h0, 4'd0);
        reset_n = 1'b1;

        // Single conversions (rr ends 1, 3, 2, 0 respectively).
        runSingle("norm", 0, 33'h0_8000_0000, 4'd3, 65'h0_8000_0000_0000_0000, 5'b00000);
        checkOutput("norm_sticky", 65'(flags_sticky), 65'd0);
        runSingle("snan", 2, 33'h0_E000_0001, 4'd5, 65'h0_E008_0000_2000_0000, 5'b10000);
        checkOutput("snan_sticky", 65'(flags_sticky), 65'(5'b10000));
        flags_clear = 1'b1;
        @(negedge clk);
        flags_clear = 1'b0;
        checkOutput("sticky_cleared", 65'(flags_sticky), 65'd0);
        runSingle("zero", 1, 33'h1_0000_0000, 4'd7, 65'h1_0000_0000_0000_0000, 5'b00000);
        runSingle("inf",  3, 33'h0_C000_0000, 4'd9, 65'h0_C000_0000_0000_0000, 5'b00000);
        checkOutput("sticky_quiet", 65'(flags_sticky), 65'd0);

        // Round robin with all requesters valid and no backpressure.
        for (int i = 0; i < NUM_REQ; i++) begin
            applyStimulus(i, 1'b1, 33'h0_8000_0000, 4'(8 + i));
        end
        for (int k = 0; k < 8; k++) begin
            #1;
            checkOutput("rr_ready", 65'(req_ready), 65'(4'b0001 << (k % 4)));
            if (k >= 2) begin
                checkOutput("rr_valid", 65'(resp_valid), 65'd1);
                checkOutput("rr_id",  65'(resp_id), 65'((k - 2) % 4));
                checkOutput("rr_tag", 65'(resp_tag), 65'(8 + (k - 2) % 4));
            end
            @(negedge clk);
        end
        req_valid = '0;
        repeat (3) @(negedge clk);
        checkOutput("rr_drained", 65'(resp_valid), 65'd0);

        // Backpressure: five stalled cycles with everyone valid (rr = 0).
        resp_ready = 1'b0;
        req_valid  = '1;
        accepts    = 0;
        for (int b = 0; b < 5; b++) begin
            #1;
            accepts += $countones(req_ready & req_valid);
            if (b >= 2) begin
                checkOutput("bp_hold_valid", 65'(resp_valid), 65'd1);
                checkOutput("bp_hold_id",    65'(resp_id), 65'd0);
                checkOutput("bp_hold_tag",   65'(resp_tag), 65'd8);
                checkOutput("bp_hold_data",  resp_data, 65'h0_8000_0000_0000_0000);
            end
            @(negedge clk);
        end
        checkOutput("bp_accepts", 65'(accepts), 65'd2);
        checkOutput("bp_ready_low", 65'(req_ready), 65'd0);

        // Release: responses continue in acceptance order 0,1,2,3.
        resp_ready = 1'b1;
        #1;
        checkOutput("rel0_id", 65'(resp_id), 65'd0);
        checkOutput("rel0_ready", 65'(req_ready), 65'(4'b0100));
        @(negedge clk);
        checkOutput("rel1_id", 65'(resp_id), 65'd1);
        checkOutput("rel1_valid", 65'(resp_valid), 65'd1);
        @(negedge clk);
        checkOutput("rel2_id", 65'(resp_id), 65'd2);
        req_valid = '0;
        @(negedge clk);
        checkOutput("rel3_id", 65'(resp_id), 65'd3);
        checkOutput("rel3_valid", 65'(resp_valid), 65'd1);
        @(negedge clk);
        checkOutput("rel_done", 65'(resp_valid), 65'd0);

        // Fill both stages from requesters 1 and 2, then reset.
        resp_ready = 1'b0;
        req_valid  = 4'b0110;
        #1;
        checkOutput("fill_ready1", 65'(req_ready), 65'(4'b0010));
        @(negedge clk);
        checkOutput("fill_ready2", 65'(req_ready), 65'(4'b0100));
        @(negedge clk);
        checkOutput("fill_full", 65'(resp_valid), 65'd1);
        req_valid = '0;
        reset_n   = 1'b0;
        @(negedge clk);
        reset_n    = 1'b1;
        resp_ready = 1'b1;
        checkOutput("flush_valid", 65'(resp_valid), 65'd0);
        req_valid = '1;
        #1;
        checkOutput("flush_rr0", 65'(req_ready), 65'(4'b0001));
        @(negedge clk);
        req_valid = '0;
        checkOutput("flush_nostale", 65'(resp_valid), 65'd0);
        @(negedge clk);
        checkOutput("post_valid", 65'(resp_valid), 65'd1);
        checkOutput("post_id", 65'(resp_id), 65'd0);
        @(negedge clk);
        checkOutput("post_empty", 65'(resp_valid), 65'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
